// File: rtl/mc_timing_gen_if.sv
// -----------------------------------------------------------------------------
// mc_timing_gen_if
//   Bundle between the machine-cycle timing generator and its neighbours.
//   The decoder drives cycles_in / movx / movx_wr, the external memory
//   interface drives wait_req; everything else is produced by the generator.
//
//   slave  : view taken by mc_timing_gen (consumes requests, drives timing)
//   master : view taken by the decoder / bus side (or a testbench)
//
//   Signals
//     cycles_in    [CYC_W]  extra machine cycles of the instruction
//     movx                  instruction is MOVX
//     movx_wr               MOVX direction, 1 = write
//     wait_req              slow-memory stretch request
//     phase                 0 = first half of state, 1 = second half
//     s_idx        [SW]     current state index, 0 = S1
//     cyc_remain   [CYC_W]  machine cycles left after the current one
//     first_cyc             first machine cycle of the instruction
//     data_cyc              MOVX data cycle
//     instr_end             final clock of the instruction (IR load)
//     ale, psen_n, rd_n, wr_n   external bus strobes
//     wait_active           current state is a stretched repeat
//     wait_timeout          one-clock pulse on a forced end of stretch
// -----------------------------------------------------------------------------
interface mc_timing_gen_if #(
    parameter int N_STATES = 6,
    parameter int CYC_W    = 2
);
    localparam int SW = $clog2(N_STATES);

    logic [CYC_W-1:0] cycles_in;
    logic             movx;
    logic             movx_wr;
    logic             wait_req;

    logic             phase;
    logic [SW-1:0]    s_idx;
    logic [CYC_W-1:0] cyc_remain;
    logic             first_cyc;
    logic             data_cyc;
    logic             instr_end;
    logic             ale;
    logic             psen_n;
    logic             rd_n;
    logic             wr_n;
    logic             wait_active;
    logic             wait_timeout;

    modport slave (
        input  cycles_in, movx, movx_wr, wait_req,
        output phase, s_idx, cyc_remain, first_cyc, data_cyc, instr_end,
               ale, psen_n, rd_n, wr_n, wait_active, wait_timeout
    );

    modport master (
        output cycles_in, movx, movx_wr, wait_req,
        input  phase, s_idx, cyc_remain, first_cyc, data_cyc, instr_end,
               ale, psen_n, rd_n, wr_n, wait_active, wait_timeout
    );
endinterface

// File: rtl/mc_timing_gen.sv
// -----------------------------------------------------------------------------
// mc_timing_gen
//   Machine-cycle timing generator for the MCU51 core. Sequences the
//   phase / state counter (S1..Sn), counts the extra machine cycles of
//   multi-cycle instructions, and produces the CODE/XDATA bus strobes.
//   One state can be stretched by wait_req for slow external memory, with
//   a bounded number of repeats.
//
//   Ports
//     clk    in   system clock, rising edge
//     reset  in   asynchronous, active-high reset
//     bus    slave view of mc_timing_gen_if (decoder inputs, timing and
//            strobe outputs)
//
//   Every output comes straight from a register. The next-state logic
//   computes the next phase/state first and derives all flags and strobes
//   from those next values, so strobe edges line up with the state update.
//
//   Stretch controller states
//     state       | meaning
//     ------------+-----------------------------------------------------
//     ST_RUN      | normal sequencing, strobes follow phase/state
//     ST_STRETCH  | WAIT_S is being repeated; strobes hold, wait_active=1
// -----------------------------------------------------------------------------
module mc_timing_gen #(
    parameter int N_STATES = 6,
    parameter int CYC_W    = 2,
    parameter int WAIT_S   = 2,
    parameter int MAX_WAIT = 3
) (
    input  logic           clk,
    input  logic           reset,
    mc_timing_gen_if.slave bus
);

    localparam int SW   = $clog2(N_STATES);
    localparam int HALF = N_STATES / 2;
    localparam int WCW  = $clog2(MAX_WAIT + 1);

    localparam logic [SW-1:0]  S_LAST  = SW'(N_STATES - 1);
    localparam logic [SW-1:0]  S_WAIT  = SW'(WAIT_S);
    localparam logic [SW-1:0]  S_ONE   = SW'(1);
    localparam logic [SW-1:0]  S_TWO   = SW'(2);
    localparam logic [SW-1:0]  S_HALF  = SW'(HALF);
    localparam logic [SW-1:0]  S_HALF1 = SW'(HALF + 1);
    localparam logic [SW-1:0]  S_HALF2 = SW'(HALF + 2);
    localparam logic [WCW-1:0] W_MAX   = WCW'(MAX_WAIT);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_STRETCH = 1'b1
    } st_t;

    // registers
    st_t              r_st;
    logic             r_phase;
    logic [SW-1:0]    r_s_idx;
    logic [CYC_W-1:0] r_cyc_remain;
    logic             r_first_cyc;
    logic             r_data_cyc;
    logic             r_instr_end;
    logic             r_ale;
    logic             r_psen_n;
    logic             r_rd_n;
    logic             r_wr_n;
    logic             r_wait_timeout;
    logic [WCW-1:0]   r_wait_cnt;
    logic             r_movx_lat;
    logic             r_movx_wr_lat;
    logic             r_strb_en;

    // next-state values
    st_t              w_st_nxt;
    logic             w_phase_nxt;
    logic [SW-1:0]    w_s_idx_nxt;
    logic [CYC_W-1:0] w_cyc_nxt;
    logic             w_first_nxt;
    logic             w_data_nxt;
    logic             w_instr_end_nxt;
    logic             w_ale_nxt;
    logic             w_psen_n_nxt;
    logic             w_rd_n_nxt;
    logic             w_wr_n_nxt;
    logic             w_tmo_nxt;
    logic [WCW-1:0]   w_wait_cnt_nxt;
    logic             w_movx_nxt;
    logic             w_movx_wr_nxt;
    logic             w_strb_en_nxt;
    logic             w_at_wait;
    logic             w_xfer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st           <= ST_RUN;
            r_phase        <= 1'b0;
            r_s_idx        <= S_LAST;
            r_cyc_remain   <= '0;
            r_first_cyc    <= 1'b0;
            r_data_cyc     <= 1'b0;
            r_instr_end    <= 1'b0;
            r_ale          <= 1'b0;
            r_psen_n       <= 1'b1;
            r_rd_n         <= 1'b1;
            r_wr_n         <= 1'b1;
            r_wait_timeout <= 1'b0;
            r_wait_cnt     <= '0;
            r_movx_lat     <= 1'b0;
            r_movx_wr_lat  <= 1'b0;
            r_strb_en      <= 1'b0;
        end else begin
            r_st           <= w_st_nxt;
            r_phase        <= w_phase_nxt;
            r_s_idx        <= w_s_idx_nxt;
            r_cyc_remain   <= w_cyc_nxt;
            r_first_cyc    <= w_first_nxt;
            r_data_cyc     <= w_data_nxt;
            r_instr_end    <= w_instr_end_nxt;
            r_ale          <= w_ale_nxt;
            r_psen_n       <= w_psen_n_nxt;
            r_rd_n         <= w_rd_n_nxt;
            r_wr_n         <= w_wr_n_nxt;
            r_wait_timeout <= w_tmo_nxt;
            r_wait_cnt     <= w_wait_cnt_nxt;
            r_movx_lat     <= w_movx_nxt;
            r_movx_wr_lat  <= w_movx_wr_nxt;
            r_strb_en      <= w_strb_en_nxt;
        end
    end

    always_comb begin
        w_st_nxt       = r_st;
        w_phase_nxt    = ~r_phase;
        w_s_idx_nxt    = r_s_idx;
        w_cyc_nxt      = r_cyc_remain;
        w_first_nxt    = r_first_cyc;
        w_tmo_nxt      = 1'b0;
        w_wait_cnt_nxt = r_wait_cnt;
        w_movx_nxt     = r_movx_lat;
        w_movx_wr_nxt  = r_movx_wr_lat;
        w_strb_en_nxt  = r_strb_en;
        w_at_wait      = (r_s_idx == S_WAIT) && bus.wait_req;
        w_xfer         = 1'b0;

        // State decisions are only taken on the second half of a state.
        if (r_phase) begin
            if (w_at_wait && (r_wait_cnt < W_MAX)) begin
                w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                w_st_nxt       = ST_STRETCH;
            end else begin
                // A request still pending here means the repeat budget ran out.
                w_tmo_nxt      = w_at_wait;
                w_wait_cnt_nxt = '0;
                w_st_nxt       = ST_RUN;
                if (r_s_idx == S_LAST) begin
                    w_s_idx_nxt   = '0;
                    w_strb_en_nxt = 1'b1;
                    if (r_cyc_remain == '0) begin
                        w_first_nxt = 1'b1;
                    end else begin
                        w_cyc_nxt = r_cyc_remain - 1'b1;
                    end
                end else begin
                    w_s_idx_nxt = r_s_idx + 1'b1;
                end
                if (r_s_idx == '0) begin
                    w_first_nxt = 1'b0;
                    if (r_first_cyc) begin
                        w_cyc_nxt     = bus.cycles_in;
                        w_movx_nxt    = bus.movx & (bus.cycles_in != '0);
                        w_movx_wr_nxt = bus.movx_wr;
                    end
                end
            end
        end

        w_instr_end_nxt = w_phase_nxt && (w_s_idx_nxt == S_LAST) && (w_cyc_nxt == '0);
        // first_cyc masks the stale descriptor during state 0 of a new instruction.
        w_data_nxt      = w_movx_nxt && (w_cyc_nxt == '0) && !w_first_nxt;

        w_ale_nxt    = r_ale;
        w_psen_n_nxt = r_psen_n;
        w_rd_n_nxt   = r_rd_n;
        w_wr_n_nxt   = r_wr_n;
        if (w_st_nxt != ST_STRETCH) begin
            w_ale_nxt    = 1'b0;
            w_psen_n_nxt = 1'b1;
            w_rd_n_nxt   = 1'b1;
            w_wr_n_nxt   = 1'b1;
            // Strobes stay quiet until the first full machine cycle after
            // reset so a reset never leaves a truncated pulse behind.
            if (w_strb_en_nxt) begin
                if (w_data_nxt) begin
                    w_ale_nxt = (w_s_idx_nxt == '0);
                    w_xfer    = (w_s_idx_nxt != '0) && (w_s_idx_nxt != S_LAST);
                    w_rd_n_nxt = ~(w_xfer & ~w_movx_wr_nxt);
                    w_wr_n_nxt = ~(w_xfer &  w_movx_wr_nxt);
                end else begin
                    w_ale_nxt    = (w_s_idx_nxt == '0) || (w_s_idx_nxt == S_HALF);
                    w_psen_n_nxt = ~(((w_s_idx_nxt == S_ONE) && w_phase_nxt)
                                   || (w_s_idx_nxt == S_TWO)
                                   || ((w_s_idx_nxt == S_HALF1) && w_phase_nxt)
                                   || (w_s_idx_nxt == S_HALF2));
                end
            end
        end
    end

    assign bus.phase        = r_phase;
    assign bus.s_idx        = r_s_idx;
    assign bus.cyc_remain   = r_cyc_remain;
    assign bus.first_cyc    = r_first_cyc;
    assign bus.data_cyc     = r_data_cyc;
    assign bus.instr_end    = r_instr_end;
    assign bus.ale          = r_ale;
    assign bus.psen_n       = r_psen_n;
    assign bus.rd_n         = r_rd_n;
    assign bus.wr_n         = r_wr_n;
    assign bus.wait_active  = (r_st == ST_STRETCH);
    assign bus.wait_timeout = r_wait_timeout;

endmodule

// File: tb/tb_mc_timing_gen.sv
module tb_mc_timing_gen;

    localparam int N    = 6;
    localparam int CW   = 2;
    localparam int WS   = 2;
    localparam int MW   = 3;
    localparam int SW   = $clog2(N);
    localparam int HALF = N / 2;

    logic clk;
    logic rst;

    mc_timing_gen_if #(.N_STATES(N), .CYC_W(CW)) bus_if ();

    mc_timing_gen #(
        .N_STATES (N),
        .CYC_W    (CW),
        .WAIT_S   (WS),
        .MAX_WAIT (MW)
    ) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference model: position inside the machine cycle (tick = 2*state+phase),
    // machine-cycle number k of the current instruction and its descriptor.
    int m_tick, m_k, m_extra, m_rep;
    bit m_movx, m_wr, m_in_rep, m_tmo, m_started;

    function automatic void model_reset();
        m_tick    = 2 * N - 2;
        m_k       = 1;
        m_extra   = 0;
        m_movx    = 0;
        m_wr      = 0;
        m_rep     = 0;
        m_in_rep  = 0;
        m_tmo     = 0;
        m_started = 0;
    endfunction

    function automatic void model_step(input int cyc, input bit mv, input bit mw, input bit wreq);
        int s;
        s     = m_tick / 2;
        m_tmo = 0;
        if (m_tick % 2 == 0) begin
            m_tick++;
        end else if (s == WS && wreq && m_rep < MW) begin
            m_rep++;
            m_in_rep = 1;
            m_tick--;
        end else begin
            if (s == WS && wreq) m_tmo = 1;
            m_rep    = 0;
            m_in_rep = 0;
            if (s == 0 && m_k == 1) begin
                m_extra = cyc;
                m_movx  = mv && (cyc != 0);
                m_wr    = mw;
            end
            if (s == N - 1) begin
                m_tick    = 0;
                m_started = 1;
                if (m_k == m_extra + 1) m_k = 1;
                else m_k++;
            end else begin
                m_tick++;
            end
        end
    endfunction

    task automatic compare_outputs();
        int s, ph, cyc_e, st;
        bit last, first, data, ie, e_ale, e_psen, e_rd, e_wr, low;
        s     = m_tick / 2;
        ph    = m_tick % 2;
        last  = (m_k == m_extra + 1);
        cyc_e = (m_k == 1 && s == 0) ? 0 : m_extra + 1 - m_k;
        first = (m_k == 1 && s == 0);
        data  = m_movx && last && (m_k > 1);
        ie    = (ph == 1) && (s == N - 1) && last;
        st    = m_in_rep ? 2 * WS + 1 : m_tick;
        e_ale = 0; e_psen = 1; e_rd = 1; e_wr = 1;
        if (m_started) begin
            if (data) begin
                e_ale = (st < 2);
                low   = (st >= 2) && (st < 2 * N - 2);
                e_rd  = !(low && !m_wr);
                e_wr  = !(low && m_wr);
            end else begin
                e_ale  = (st < 2) || (st >= 2 * HALF && st < 2 * HALF + 2);
                e_psen = !((st >= 3 && st <= 5) || (st >= 2 * HALF + 3 && st <= 2 * HALF + 5));
            end
        end
        check_eq("seq{ph,s,cyc,first,data,ie}",
                 32'({bus_if.phase, bus_if.s_idx, bus_if.cyc_remain, bus_if.first_cyc,
                      bus_if.data_cyc, bus_if.instr_end}),
                 32'({1'(ph), SW'(s), CW'(cyc_e), first, data, ie}));
        check_eq("strb{ale,psen,rd,wr,wact,wtmo}",
                 32'({bus_if.ale, bus_if.psen_n, bus_if.rd_n, bus_if.wr_n,
                      bus_if.wait_active, bus_if.wait_timeout}),
                 32'({e_ale, e_psen, e_rd, e_wr, m_in_rep, m_tmo}));
    endtask

    // Stimulus modes: 0 idle fetch, 1 random, 2 wait stuck, 3 movx read,
    // 4 movx write, 6 two-repeat stretch, 7 three-cycle instructions
    int mode  = 0;
    int wprob = 1;
    int have_prev, ie_gap, s2_run, wa_run, tmo_run, rd_run, wr_run;

    function automatic void clear_trackers();
        have_prev = 0; ie_gap = 0; s2_run = 0; wa_run = 0;
        tmo_run = 0; rd_run = 0; wr_run = 0;
    endfunction

    function automatic void set_mode(input int m);
        mode = m;
        clear_trackers();
    endfunction

    task automatic drive_inputs();
        bus_if.cycles_in = '0;
        bus_if.movx      = 1'b0;
        bus_if.movx_wr   = 1'b0;
        bus_if.wait_req  = 1'b0;
        case (mode)
            1: begin
                bus_if.cycles_in = CW'($urandom_range(0, 3));
                bus_if.movx      = 1'($urandom_range(0, 1));
                bus_if.movx_wr   = 1'($urandom_range(0, 1));
                bus_if.wait_req  = ($urandom_range(0, 3) < wprob);
            end
            2: bus_if.wait_req = 1'b1;
            3: begin bus_if.cycles_in = CW'(1); bus_if.movx = 1'b1; end
            4: begin bus_if.cycles_in = CW'(1); bus_if.movx = 1'b1; bus_if.movx_wr = 1'b1; end
            6: bus_if.wait_req = (int'(bus_if.s_idx) == WS) && (s2_run <= 4);
            7: bus_if.cycles_in = CW'(2);
            default: ;
        endcase
    endtask

    task automatic observe();
        int e_per, e_s2, e_wa;
        if (rst) begin
            clear_trackers();
            return;
        end
        e_per = -1; e_s2 = -1; e_wa = -1;
        case (mode)
            0: begin e_per = 2 * N;          e_s2 = 2;          end
            2: begin e_per = 2 * N + 2 * MW; e_s2 = 2 * (MW + 1); e_wa = 2 * MW; end
            3, 4: e_per = 4 * N;
            6: begin e_per = 2 * N + 4;      e_s2 = 6;          e_wa = 4; end
            7: e_per = 6 * N;
            default: ;
        endcase
        ie_gap++;
        if (bus_if.instr_end) begin
            if (have_prev != 0 && e_per > 0) check_eq("ie_period", 32'(ie_gap), 32'(e_per));
            have_prev = 1;
            ie_gap    = 0;
        end
        if (int'(bus_if.s_idx) == WS) s2_run++;
        else begin
            if (s2_run > 0 && have_prev != 0 && e_s2 > 0) check_eq("s2_len", 32'(s2_run), 32'(e_s2));
            s2_run = 0;
        end
        if (bus_if.wait_active) wa_run++;
        else begin
            if (wa_run > 0 && have_prev != 0 && e_wa > 0) check_eq("wact_len", 32'(wa_run), 32'(e_wa));
            wa_run = 0;
        end
        if (bus_if.wait_timeout) tmo_run++;
        else begin
            if (tmo_run > 0) check_eq("wtmo_width", 32'(tmo_run), 32'd1);
            tmo_run = 0;
        end
        if (!bus_if.rd_n) rd_run++;
        else begin
            if (rd_run > 0 && have_prev != 0 && mode == 3) check_eq("rd_low_len", 32'(rd_run), 32'(2 * (N - 2)));
            rd_run = 0;
        end
        if (!bus_if.wr_n) wr_run++;
        else begin
            if (wr_run > 0 && have_prev != 0 && mode == 4) check_eq("wr_low_len", 32'(wr_run), 32'(2 * (N - 2)));
            wr_run = 0;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive_inputs();
            @(posedge clk);
            if (rst) model_reset();
            else model_step(int'(bus_if.cycles_in), bus_if.movx, bus_if.movx_wr, bus_if.wait_req);
            @(negedge clk);
            compare_outputs();
            observe();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;
        rst = 1'b1;
        set_mode(0);
        drive_inputs();
        model_reset();
        @(negedge clk);
        compare_outputs();
        check_eq("rst_s_idx", 32'(bus_if.s_idx), 32'(N - 1));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compare_outputs();
        run_cycles(1);
        check_eq("ie_clk2", 32'(bus_if.instr_end), 32'd1);
        run_cycles(1);
        check_eq("s0_clk3", 32'({bus_if.phase, bus_if.s_idx}), 32'd0);
        check_eq("first_clk3", 32'(bus_if.first_cyc), 32'd1);
        run_cycles(60);

        set_mode(7); run_cycles(120);
        wprob = 1; set_mode(1); run_cycles(900);
        set_mode(6); run_cycles(100);
        set_mode(2); run_cycles(120);
        set_mode(4); run_cycles(80);
        set_mode(3); run_cycles(60);

        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            run_cycles(1);
            if (!bus_if.rd_n && bus_if.data_cyc && rd_run >= 3) found = 1;
        end
        check_eq("rd_low_seen", 32'(found), 32'd1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        check_eq("rd_n_async", 32'(bus_if.rd_n), 32'd1);
        clear_trackers();
        run_cycles(2);
        set_mode(0);
        rst = 1'b0;
        compare_outputs();
        run_cycles(1);
        check_eq("ie_clk2_after_rst", 32'(bus_if.instr_end), 32'd1);
        run_cycles(40);

        wprob = 3; set_mode(1); run_cycles(600);
        set_mode(0); run_cycles(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_timing_gen.md
# mc_timing_gen

Parametrised machine-cycle timing generator for the MCU51 core. It produces the phase/state sequence (S1..Sn), the multi-cycle instruction counter and the external bus strobes (ALE, PSEN, RD, WR). It is the successor to the fixed six-state, two-bit-cycle sequencing in the control unit: state count is configurable, MOVX read and write are distinguished, and a bounded wait-state handshake stretches bus access for slow external memory. It sits between the instruction decoder (which supplies the cycle count and MOVX flags) and the CODE/XDATA bus interface.

## Interface
- N_STATES, 6: states per machine cycle. Must be even and ≥ 6. HALF = N_STATES/2.
- CYC_W, 2: width of the extra-machine-cycle count.
- WAIT_S, 2: state index that may be stretched. Legal range 1..N_STATES-2.
- MAX_WAIT, 3: maximum consecutive stretched repeats of WAIT_S, ≥ 1.
- SW: derived, clog2(N_STATES).

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cycles_in  in  CYC_W  extra machine cycles of the current instruction (0 = single cycle)
- movx  in  1  current instruction is MOVX
- movx_wr  in  1  MOVX direction: 1 = write, 0 = read
- wait_req  in  1  slow-memory stretch request
- phase  out  1  0 = first half of state, 1 = second half
- s_idx  out  SW  current state index; 0 = S1
- cyc_remain  out  CYC_W  machine cycles remaining after the current one
- first_cyc  out  1  current machine cycle is the first of its instruction
- data_cyc  out  1  current machine cycle is a MOVX data cycle
- instr_end  out  1  final clock of the instruction; IR load strobe
- ale  out  1  address latch enable, active high
- psen_n  out  1  program store enable, active low
- rd_n, wr_n  out  1  external data strobes, active low
- wait_active  out  1  the current state is a stretched repeat
- wait_timeout  out  1  one-clock pulse when a stretch is forcibly ended

## Operation
- All outputs are driven only from registers. There is no combinational path from any input to any output.
- Reset values: phase = 0, s_idx = N_STATES-1, cyc_remain = 0, first_cyc = 0, data_cyc = 0, instr_end = 0, ale = 0, psen_n = 1, rd_n = 1, wr_n = 1, wait_active = 0, wait_timeout = 0. Internal state: wait_cnt = 0, movx_lat = 0, movx_wr_lat = 0.
- Phase toggles every clock. The state advances at the end of phase 1, wrapping from N_STATES-1 to 0.
- Stretch:
  - At the phase-1 clock of s_idx = WAIT_S, if wait_req = 1 and wait_cnt < MAX_WAIT, the state repeats (both phases) and wait_cnt increments.
  - wait_active = 1 during each repeat.
  - If wait_req = 1 and wait_cnt = MAX_WAIT, the state advances anyway and wait_timeout pulses on that clock.
  - wait_cnt clears whenever the state advances.
- Instruction end:
  - instr_end = 1 on the phase-1 clock of s_idx = N_STATES-1 when cyc_remain = 0.
  - After instr_end, first_cyc = 1 until the end of state 0.
- Cycle load and count:
  - At the phase-1 clock of state 0 with first_cyc = 1, the block samples cycles_in into cyc_remain.
  - On the same clock it latches movx_lat = movx & (cycles_in ≠ 0) and movx_wr_lat = movx_wr.
  - cyc_remain decrements at the end of state N_STATES-1 when it is non-zero. It does not wrap.
- data_cyc = 1 for the final machine cycle of an instruction with movx_lat = 1 (not the first cycle).
- Strobes in fetch cycles (data_cyc = 0):
  - ale = 1 for all of states 0 and HALF.
  - psen_n = 0 on phase 1 of state 1 and all of state 2.
  - psen_n = 0 on phase 1 of state HALF+1 and all of state HALF+2.
  - psen_n = 1 otherwise.
- Strobes in data cycles (data_cyc = 1):
  - ale = 1 in state 0 only.
  - psen_n = 1 throughout.
  - For states 1..N_STATES-2: rd_n = 0 if movx_wr_lat = 0, otherwise wr_n = 0.
- Strobes hold their values during stretched repeats.
- Changes to cycles_in, movx and movx_wr are ignored outside the sampling clock.
- Asynchronous reset at any point, including mid-stretch or mid-data-cycle, immediately forces the reset values. The strobes deassert with no partial pulse afterwards.

## Timing
- One state is 2 clocks. One machine cycle is 2·N_STATES clocks plus 2 clocks per stretched repeat.
- From reset release, the first instr_end occurs on clock 2. The first fetch state 0 begins on clock 3.
- instr_end pulses are separated by 2·N_STATES·(1+cycles_in) clocks plus stretch clocks.
- Strobe edges coincide with the phase/state register update. No extra output latency.

## Test plan
- N_STATES=6, cycles_in = 0, no wait_req → instr_end every 12 clocks. ale high 2 clocks at s_idx 0 and 3. psen_n low 3 clocks starting at phase 1 of s_idx 1, and again at s_idx 4.
- cycles_in = 2 → cyc_remain reads 2, 1, 0 across three machine cycles; instr_end every 36 clocks; first_cyc high only through state 0 of cycle 1.
- movx = 1, movx_wr = 0, cycles_in = 1 → in cycle 2: data_cyc = 1, psen_n stays 1, ale only at s_idx 0, rd_n low 8 clocks (s_idx 1..4), wr_n stays 1. Repeat with movx_wr = 1 → wr_n low 8 clocks, rd_n stays 1.
- wait_req high for 2 states at s_idx 2 → s_idx 2 lasts 6 clocks, wait_active high 4 clocks, instr period 16 clocks, no wait_timeout.
- wait_req stuck high, MAX_WAIT = 3 → s_idx 2 lasts 8 clocks; wait_timeout is a single 1-clock pulse on the forced advance; the next instruction stretches identically.
- Assert reset mid-data-cycle while rd_n = 0 → rd_n = 1 and all outputs at reset values immediately. After release, normal fetch resumes with instr_end on clock 2.
